// File: rtl/cipher_pkg.sv
// Shared constants for the 128-bit block-cipher datapath: S-box tables,
// lane widths and the round-constant list consumed by hw_imp.
package cipher_pkg;

  localparam int NIB_W  = 4;
  localparam int WORD_W = 32;
  localparam int N_NIB  = 8;

  localparam logic [NIB_W-1:0] SBOX_FWD [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  localparam logic [NIB_W-1:0] SBOX_INV [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  localparam int N_RCON = 12;
  localparam logic [7:0] RCON [N_RCON] = '{
    8'h5A, 8'h34, 8'h73, 8'h66, 8'h57, 8'h35,
    8'h71, 8'h62, 8'h5F, 8'h25, 8'h51, 8'h22
  };

endpackage

// File: rtl/sbox_nibble.sv
// Combinational 4-bit S-box lookup; inverse selects the decrypt table.
module sbox_nibble
  import cipher_pkg::*;
(
  input  logic [NIB_W-1:0] i_nib,
  input  logic             i_inverse,
  output logic [NIB_W-1:0] o_nib
);

  always_comb begin
    o_nib = SBOX_FWD[i_nib];
    if (i_inverse) o_nib = SBOX_INV[i_nib];
  end

endmodule

// File: rtl/sbox_layer.sv
// 32-bit substitution layer: eight parallel S-box lanes with a registered
// output, one word per clock, one cycle of latency.
module sbox_layer
  import cipher_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              inverse,
  input  logic [WORD_W-1:0] inText,
  output logic [WORD_W-1:0] outText,
  output logic              out_valid
);

  logic [WORD_W-1:0] w_sub;
  logic [WORD_W-1:0] r_out;
  logic              r_valid;

  // Lanes map in place; no nibble reordering.
  for (genvar g = 0; g < N_NIB; g++) begin : g_lane
    sbox_nibble u_nib (
      .i_nib     (inText[g*NIB_W +: NIB_W]),
      .i_inverse (inverse),
      .o_nib     (w_sub[g*NIB_W +: NIB_W])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) r_out <= w_sub;
    end
  end

  assign outText   = r_out;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_sbox_layer.sv
// Directed bench for sbox_layer with hand-computed expected words.
module tb_sbox_layer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        inverse;
  logic [31:0] inText;
  logic [31:0] outText;
  logic        out_valid;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] fwd_t [16] = '{4'hC,4'h5,4'h6,4'hB,4'h9,4'h0,4'hA,4'hD,
                             4'h3,4'hE,4'hF,4'h8,4'h4,4'h7,4'h1,4'h2};

  sbox_layer dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .inverse   (inverse),
    .inText    (inText),
    .outText   (outText),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic step(input logic rst, input logic v, input logic inv, input logic [31:0] d);
    reset    = rst;
    in_valid = v;
    inverse  = inv;
    inText   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; inverse = 1'b0; inText = '0;
    @(posedge clk); #1;

    // reset dominates a valid input
    step(1'b1, 1'b1, 1'b0, 32'hFFFFFFFF);
    chk("rst0_data", outText, 32'h0);
    chk("rst0_valid", {31'b0, out_valid}, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'hFFFFFFFF);
    chk("rst1_data", outText, 32'h0);
    chk("rst1_valid", {31'b0, out_valid}, 32'h0);

    step(1'b0, 1'b1, 1'b0, 32'h01234567);
    chk("fwd_basic", outText, 32'hC56B90AD);
    chk("fwd_basic_v", {31'b0, out_valid}, 32'h1);
    step(1'b0, 1'b0, 1'b1, 32'hFFFFFFFF);
    chk("hold_data", outText, 32'hC56B90AD);
    chk("hold_valid", {31'b0, out_valid}, 32'h0);

    step(1'b0, 1'b1, 1'b0, 32'h00000000);
    chk("fwd_zero", outText, 32'hCCCCCCCC);
    step(1'b0, 1'b1, 1'b0, 32'hFFFFFFFF);
    chk("fwd_ones", outText, 32'h22222222);
    step(1'b0, 1'b1, 1'b0, 32'h89ABCDEF);
    chk("fwd_hi", outText, 32'h3EF84712);
    step(1'b0, 1'b1, 1'b1, 32'hC56B90AD);
    chk("inv_basic", outText, 32'h01234567);

    // every value in every lane: forward against the table, then inverse back
    for (int x = 0; x < 16; x++) begin
      logic [3:0] n;
      logic [3:0] s;
      n = x[3:0];
      s = fwd_t[x];
      step(1'b0, 1'b1, 1'b0, {8{n}});
      chk($sformatf("fwd_lane_%0h", n), outText, {8{s}});
      step(1'b0, 1'b1, 1'b1, {8{s}});
      chk($sformatf("inv_lane_%0h", n), outText, {8{n}});
    end

    // back-to-back mixed direction
    reset = 1'b0; in_valid = 1'b1; inverse = 1'b0; inText = 32'h01234567;
    @(posedge clk); #1;
    inverse = 1'b1; inText = 32'hC56B90AD;
    chk("strm0", outText, 32'hC56B90AD);
    chk("strm0_v", {31'b0, out_valid}, 32'h1);
    @(posedge clk); #1;
    inverse = 1'b0; inText = 32'h89ABCDEF;
    chk("strm1", outText, 32'h01234567);
    chk("strm1_v", {31'b0, out_valid}, 32'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("strm2", outText, 32'h3EF84712);
    chk("strm2_v", {31'b0, out_valid}, 32'h1);

    // reset mid-stream discards the word on that edge
    step(1'b1, 1'b1, 1'b0, 32'h01234567);
    chk("midrst_data", outText, 32'h0);
    chk("midrst_valid", {31'b0, out_valid}, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h00000000);
    chk("post_rst", outText, 32'hCCCCCCCC);
    chk("post_rst_v", {31'b0, out_valid}, 32'h1);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("idle_v", {31'b0, out_valid}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
